nvdla_cacc_csb_slave: RTL
=========================

// Module: nvdla_cacc_csb_slave
// PURPOSE
//  CSB register-slave front end for CACC. Sits directly downstream of the 3-stage CSB retiming pipe.
//  Buffers incoming CSB request packets, because the retiming pipe ties prdy high and cannot be back-pressured.
//  Decodes each packet, drives one access at a time on the CACC register-file interface, and returns
//  34-bit response packets to the retiming pipe's response input.
// PARAMETERS
//  FIFO_DEPTH  4      request buffer entries (power of 2, >=2)
//  ADDR_BASE   22'h0  word-address base of the CACC register window
//  ADDR_SPAN   1024   window size in 32-bit words; addr outside [BASE, BASE+SPAN) -> error response
// PORTS
//  nvdla_core_clk         in   1   clock
//  nvdla_core_rst         in   1   asynchronous active-high reset
//  csb2cacc_req_pvld      in   1   request valid; every valid cycle is one packet, no ready
//  csb2cacc_req_pd        in   63  {level[62:61],wrbe[60:57],srcpriv[56],nposted[55],write[54],wdat[53:22],addr[21:0]}
//  cacc2csb_resp_valid    out  1   single-cycle response pulse
//  cacc2csb_resp_pd       out  34  {type[33] (0=read,1=write), error[32], rdat[31:0]}
//  reg_vld                out  1   register access request
//  reg_wr                 out  1   1=write, 0=read (valid with reg_vld)
//  reg_offset             out  12  byte offset = (addr-ADDR_BASE)<<2, [1:0]=0
//  reg_wr_data            out  32  write data
//  reg_wr_be              out  4   write byte enables
//  reg_ack                in   1   access complete; may be asserted in the same cycle as reg_vld
//  reg_rd_data            in   32  read data, sampled when reg_ack=1
//  reg_err                in   1   access error, sampled when reg_ack=1
//  req_overflow           out  1   sticky: a packet arrived while the FIFO was full
// BEHAVIOUR
//  Reset: cacc2csb_resp_valid=0, cacc2csb_resp_pd=0, reg_vld=0, reg_wr=0, reg_offset=0, reg_wr_data=0,
//   reg_wr_be=0, req_overflow=0, FIFO empty, FSM=IDLE.
//  FIFO: push on req_pvld when not full. A packet arriving while full is dropped and sets req_overflow.
//   req_overflow clears only on reset. Push and pop in the same cycle are legal; when full, the pop
//   frees no slot for that same cycle's push. Pointers wrap modulo FIFO_DEPTH.
//  FSM states IDLE, ACCESS, RESP:
//   IDLE: if FIFO non-empty, pop the head and register the decoded fields.
//    In-window -> ACCESS with reg_vld=1 next cycle.
//    Out-of-window -> RESP with error=1, rdat=0; no register access.
//   ACCESS: hold reg_vld and all reg_* stable until reg_ack. On ack, capture rd_data/err, then go to RESP.
//    No timeout: waits forever on reg_ack.
//   RESP: drive one response, or none, for one cycle, then return to IDLE.
//    Read -> response type=0, error=err, rdat=reg_rd_data (0 if error).
//    Write with nposted=1 -> response type=1, error=err, rdat=0.
//    Write with nposted=0 -> no response pulse.
//  Latency: packet into an empty FIFO in cycle N; reg_vld in N+2; with ack in N+2, response valid in N+3.
//   Back-to-back throughput is one access per 3 cycles with zero-wait ack.
//  Ordering: responses return strictly in request order. At most one access is outstanding.
//  level and srcpriv are ignored. reg_wr_be = wrbe for writes, 4'h0 for reads.
//  Reset mid-access: the FSM aborts to IDLE, the FIFO is flushed, and no response is emitted.
// TESTING
//  1 Read addr=BASE+5, ack same cycle, rd_data=32'hDEADBEEF -> reg_offset=12'h014; resp_pd=34'h0_DEADBEEF at N+3.
//  2 Non-posted write addr=BASE+1, wdat=32'h1234, wrbe=4'hF, ack after 4 waits -> reg_* stable 5 cycles;
//    resp_pd={1,0,32'h0}. Same write with nposted=0 -> no resp pulse.
//  3 Read addr=BASE+ADDR_SPAN -> no reg_vld; resp_pd={0,1,32'h0}.
//  4 Six back-to-back reads with reg_ack held low -> packets 1-5 buffered (1 in flight + 4 queued),
//    packet 6 dropped, req_overflow=1; after acks, exactly 5 in-order responses.
//  5 Read with reg_err=1 -> resp_pd={0,1,32'h0}.
//    Assert reset while in ACCESS -> reg_vld=0 immediately, no response, clean operation after release.
//  6 Interleave read/write/posted-write stream -> responses match a scoreboard in order and count.

Source files
------------

// File: rtl/nvdla_cacc_csb_slave.sv
// CSB request buffer and single-outstanding register-file sequencer for CACC.
// Packets are queued (the retiming pipe cannot stall), decoded, issued one at a time, and answered in order.
module nvdla_cacc_csb_slave #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [21:0] ADDR_BASE  = 22'h0,
    parameter int unsigned ADDR_SPAN  = 1024
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        csb2cacc_req_pvld,
    input  logic [62:0] csb2cacc_req_pd,
    output logic        cacc2csb_resp_valid,
    output logic [33:0] cacc2csb_resp_pd,
    output logic        reg_vld,
    output logic        reg_wr,
    output logic [11:0] reg_offset,
    output logic [31:0] reg_wr_data,
    output logic [3:0]  reg_wr_be,
    input  logic        reg_ack,
    input  logic [31:0] reg_rd_data,
    input  logic        reg_err,
    output logic        req_overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 60;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [ENT_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full, fifo_empty, push, pop;
    logic               ovf_q, ovf_d;

    logic [ENT_W-1:0]   push_entry, head;
    logic               head_nposted, head_write, head_in_win;
    logic [3:0]         head_wrbe;
    logic [31:0]        head_wdat;
    logic [21:0]        head_addr, head_off;
    logic               unused_req_bits;

    logic               resp_valid_q, resp_valid_d;
    logic [33:0]        resp_pd_q, resp_pd_d;
    logic               reg_vld_q, reg_vld_d;
    logic               reg_wr_q, reg_wr_d;
    logic [11:0]        reg_offset_q, reg_offset_d;
    logic [31:0]        reg_wr_data_q, reg_wr_data_d;
    logic [3:0]         reg_wr_be_q, reg_wr_be_d;
    logic               acc_write_q, acc_write_d;
    logic               acc_nposted_q, acc_nposted_d;

    // level and srcpriv carry no meaning for this slave
    assign unused_req_bits = ^{csb2cacc_req_pd[62:61], csb2cacc_req_pd[56]};

    assign push_entry = {csb2cacc_req_pd[55], csb2cacc_req_pd[54], csb2cacc_req_pd[60:57],
                         csb2cacc_req_pd[53:22], csb2cacc_req_pd[21:0]};

    // Full is judged before this cycle's pop, so a pop never frees a slot for a same-cycle push
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = csb2cacc_req_pvld & ~fifo_full;
    assign pop        = (state_q == IDLE) & ~fifo_empty;

    assign head         = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_nposted = head[59];
    assign head_write   = head[58];
    assign head_wrbe    = head[57:54];
    assign head_wdat    = head[53:22];
    assign head_addr    = head[21:0];
    assign head_off     = head_addr - ADDR_BASE;
    assign head_in_win  = (head_addr >= ADDR_BASE) && ({1'b0, head_off} < 23'(ADDR_SPAN));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
        if (pop) rd_ptr_d = rd_ptr_q + CNT_W'(1);
        if (csb2cacc_req_pvld && fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (push) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry;
    end

    // State register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) state_q <= IDLE;
        else                state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = head_in_win ? ACCESS : RESP;
            ACCESS:  if (reg_ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and access-context logic; the response is staged so it is visible while in RESP
    always_comb begin
        resp_valid_d  = 1'b0;
        resp_pd_d     = resp_pd_q;
        reg_vld_d     = reg_vld_q;
        reg_wr_d      = reg_wr_q;
        reg_offset_d  = reg_offset_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_be_d   = reg_wr_be_q;
        acc_write_d   = acc_write_q;
        acc_nposted_d = acc_nposted_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    acc_write_d   = head_write;
                    acc_nposted_d = head_nposted;
                    reg_wr_d      = head_write;
                    reg_offset_d  = 12'({head_off, 2'b00});
                    reg_wr_data_d = head_wdat;
                    reg_wr_be_d   = head_write ? head_wrbe : 4'h0;
                    reg_vld_d     = head_in_win;
                    if (!head_in_win && (!head_write || head_nposted)) begin
                        resp_valid_d = 1'b1;
                        resp_pd_d    = {head_write, 1'b1, 32'h0};
                    end
                end
            end
            ACCESS: begin
                if (reg_ack) begin
                    reg_vld_d = 1'b0;
                    if (!acc_write_q || acc_nposted_q) begin
                        resp_valid_d = 1'b1;
                        resp_pd_d    = {acc_write_q, reg_err,
                                        (acc_write_q || reg_err) ? 32'h0 : reg_rd_data};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ovf_q         <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_pd_q     <= '0;
            reg_vld_q     <= 1'b0;
            reg_wr_q      <= 1'b0;
            reg_offset_q  <= '0;
            reg_wr_data_q <= '0;
            reg_wr_be_q   <= '0;
            acc_write_q   <= 1'b0;
            acc_nposted_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ovf_q         <= ovf_d;
            resp_valid_q  <= resp_valid_d;
            resp_pd_q     <= resp_pd_d;
            reg_vld_q     <= reg_vld_d;
            reg_wr_q      <= reg_wr_d;
            reg_offset_q  <= reg_offset_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_be_q   <= reg_wr_be_d;
            acc_write_q   <= acc_write_d;
            acc_nposted_q <= acc_nposted_d;
        end
    end

    assign cacc2csb_resp_valid = resp_valid_q;
    assign cacc2csb_resp_pd    = resp_pd_q;
    assign reg_vld             = reg_vld_q;
    assign reg_wr              = reg_wr_q;
    assign reg_offset          = reg_offset_q;
    assign reg_wr_data         = reg_wr_data_q;
    assign reg_wr_be           = reg_wr_be_q;
    assign req_overflow        = ovf_q;

endmodule
